// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline buffer: HDMI reads the front bank while the renderer
// fills the back bank; an optional clear engine blanks the back bank after each swap.
module ppu_line_buffer #(
  parameter int unsigned       DATA_W        = 10,
  parameter int unsigned       LINE_W        = 320,
  parameter int unsigned       ADDR_W        = $clog2(LINE_W),
  parameter logic [DATA_W-1:0] CLEAR_VAL     = '0,
  parameter bit                CLEAR_ON_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              line_swap,
  output logic              front_bank,
  output logic              swap_err
);

  localparam logic [ADDR_W:0]   LINE_LIM = (ADDR_W+1)'(LINE_W);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(LINE_W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                pend_q, pend_d;
  logic                front_q, front_d;
  logic                swap_err_q, swap_err_d;
  logic                wr_ready_q, wr_ready_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                swap_go;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   bank0_mem [LINE_W];
  logic [DATA_W-1:0]   bank1_mem [LINE_W];

  logic                rd_in_range;
  logic                wr_in_range;

  assign rd_in_range = ({1'b0, rd_addr} < LINE_LIM);
  assign wr_in_range = ({1'b0, wr_addr} < LINE_LIM);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_SWAP) state_q <= S_CLEAR;
      else               state_q <= S_IDLE;
      clr_addr_q <= '0;
      pend_q     <= 1'b0;
      front_q    <= 1'b0;
      swap_err_q <= 1'b0;
      wr_ready_q <= ~CLEAR_ON_SWAP;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pend_q     <= pend_d;
      front_q    <= front_d;
      swap_err_q <= swap_err_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next state: clear sweep, pending swap and bank exchange
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pend_d     = pend_q;
    front_d    = front_q;
    swap_err_d = 1'b0;
    swap_go    = 1'b0;

    unique case (state_q)
      S_IDLE: swap_go = line_swap;
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == CLR_LAST) begin
          // Completion cycle behaves as IDLE plus any pending swap.
          swap_go    = pend_q | line_swap;
          swap_err_d = pend_q & line_swap;
          pend_d     = 1'b0;
          state_d    = S_IDLE;
        end else if (line_swap) begin
          if (pend_q) swap_err_d = 1'b1;
          else        pend_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (swap_go) begin
      front_d = ~front_q;
      if (CLEAR_ON_SWAP) begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
    end
  end

  // Outputs: back-bank write port, read mux, ready flag
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = CLEAR_VAL;
    end else if (wr_en && wr_in_range) begin
      mem_we = 1'b1;
    end

    rd_data_d = CLEAR_VAL;
    if (rd_in_range) rd_data_d = front_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];

    wr_ready_d = (state_d == S_IDLE);
  end

  // Storage is never reset; writes always target the back bank
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_q) bank0_mem[mem_waddr] <= mem_wdata;
      else         bank1_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data    = rd_data_q;
  assign wr_ready   = wr_ready_q;
  assign front_bank = front_q;
  assign swap_err   = swap_err_q;

endmodule

// File: tb/tb_ppu_line_buffer.sv
// Randomized bench for ppu_line_buffer against a bank/busy-counter reference model.
module tb_ppu_line_buffer;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned LINE   = 320;
  localparam int unsigned ADDR_W = 9;
  localparam logic [DATA_W-1:0] CV = 10'h2A5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              line_swap = 1'b0;
  logic              front_bank;
  logic              swap_err;

  ppu_line_buffer #(
    .DATA_W(DATA_W), .LINE_W(LINE), .ADDR_W(ADDR_W),
    .CLEAR_VAL(CV), .CLEAR_ON_SWAP(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .line_swap(line_swap), .front_bank(front_bank), .swap_err(swap_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int mem   [2][LINE];
  bit known [2][LINE];
  int m_front;
  int m_busy;
  bit m_pend;
  int ex_rd;
  bit ex_rd_ok;
  bit ex_err;

  int tog_cnt, err_cnt;
  logic prev_front;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_back();
    for (int i = 0; i < int'(LINE); i++) begin
      mem[1-m_front][i]   = int'(CV);
      known[1-m_front][i] = 1'b1;
    end
    m_busy = LINE;
  endtask

  task automatic model_reset();
    m_front  = 0;
    m_pend   = 1'b0;
    ex_rd    = 0;
    ex_rd_ok = 1'b1;
    ex_err   = 1'b0;
    fill_back();
  endtask

  task automatic model_step(input bit sw, input bit we, input int wa, input int wd, input int ra);
    bit go;
    go = 1'b0;
    ex_err = 1'b0;
    if (ra >= int'(LINE)) begin
      ex_rd = int'(CV); ex_rd_ok = 1'b1;
    end else begin
      ex_rd = mem[m_front][ra]; ex_rd_ok = known[m_front][ra];
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        go = m_pend | sw;
        ex_err = m_pend & sw;
        m_pend = 1'b0;
      end else if (sw) begin
        if (m_pend) ex_err = 1'b1;
        else        m_pend = 1'b1;
      end
    end else begin
      if (we && wa < int'(LINE)) begin
        mem[1-m_front][wa]   = wd;
        known[1-m_front][wa] = 1'b1;
      end
      go = sw;
    end
    if (go) begin
      m_front = 1 - m_front;
      fill_back();
    end
  endtask

  task automatic cyc(input bit sw, input bit we, input int wa, input int wd, input int ra);
    @(negedge clk);
    line_swap = sw;
    wr_en     = we;
    wr_addr   = ADDR_W'(wa);
    wr_data   = DATA_W'(wd);
    rd_addr   = ADDR_W'(ra);
    @(posedge clk);
    model_step(sw, we, wa, wd, ra);
    #1;
    if (ex_rd_ok) check("rd_data", 32'(rd_data), 32'(ex_rd));
    check("front_bank", 32'(front_bank), 32'(m_front));
    check("wr_ready", 32'(wr_ready), 32'(m_busy == 0));
    check("swap_err", 32'(swap_err), 32'(ex_err));
    if (front_bank !== prev_front) tog_cnt++;
    if (swap_err === 1'b1) err_cnt++;
    prev_front = front_bank;
  endtask

  task automatic cyc_rand(input bit sw);
    cyc(sw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 350)),
        int'($urandom_range(0, 1023)), int'($urandom_range(0, 400)));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 1000 && m_busy != 0; i++) cyc_rand(1'b0);
    check("ready_wait", 32'(wr_ready), 32'd1);
  endtask

  task automatic reset_now();
    // Asynchronous assertion mid-cycle, held across an edge, released mid-phase
    #2 rst_n = 1'b0;
    #1;
    check("rst_front", 32'(front_bank), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_err", 32'(swap_err), 32'd0);
    line_swap = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    prev_front = front_bank;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < int'(LINE); i++) begin
        mem[b][i] = 0; known[b][i] = 1'b0;
      end
    tog_cnt = 0; err_cnt = 0;

    // Power-on reset and initial clear; writes during the clear must be dropped
    repeat (3) @(posedge clk);
    #1;
    check("por_front", 32'(front_bank), 32'd0);
    check("por_rd", 32'(rd_data), 32'd0);
    check("por_ready", 32'(wr_ready), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    prev_front = front_bank;
    for (int i = 0; i < int'(LINE); i++) cyc(1'b0, 1'b1, i, 10'h3FF, 0);
    repeat (5) cyc(1'b0, 1'b0, 0, 0, 0);

    // Swap to the cleared bank and sweep every address
    cyc(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < int'(LINE); i++) cyc(1'b0, 1'b0, 0, 0, i);
    wait_ready();

    // Ping-pong fill with i+5, out-of-range writes, then swap and read back
    for (int i = 0; i < int'(LINE); i++) cyc(1'b0, 1'b1, i, i + 5, int'($urandom_range(0, 400)));
    cyc(1'b0, 1'b1, 320, 10'h111, 17);
    cyc(1'b0, 1'b1, 400, 10'h222, 400);
    cyc(1'b1, 1'b1, 3, 10'h0AB, 17);
    cyc(1'b0, 1'b0, 0, 0, 17);
    cyc(1'b0, 1'b0, 0, 0, 18);
    for (int i = 0; i < int'(LINE); i++) cyc(1'b0, 1'b1, i, 10'h155, i);

    // Second swap at cycle 100 of the clear executes on completion
    wait_ready();
    cyc(1'b1, 1'b0, 0, 0, 0);
    repeat (99) cyc_rand(1'b0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    repeat (700) cyc_rand(1'b0);

    // Three swaps within one clear: one error, two toggles
    wait_ready();
    tog_cnt = 0; err_cnt = 0;
    cyc(1'b1, 1'b0, 0, 0, 0);
    repeat (49) cyc_rand(1'b0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    repeat (49) cyc_rand(1'b0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    repeat (800) cyc_rand(1'b0);
    check("overrun_errs", 32'(err_cnt), 32'd1);
    check("overrun_toggles", 32'(tog_cnt), 32'd2);

    // Free-running random traffic
    for (int i = 0; i < 3000; i++) cyc_rand($urandom_range(0, 63) == 0);

    // Reset at clear cycle 150, then a full fresh clear
    wait_ready();
    cyc(1'b1, 1'b0, 0, 0, 0);
    repeat (150) cyc_rand(1'b0);
    reset_now();
    for (int i = 0; i < int'(LINE) + 10; i++) cyc_rand(1'b0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < int'(LINE); i++) cyc(1'b0, 1'b0, 0, 0, i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
